// File: rtl/uart_freq_pkg.sv
// rtl/uart_freq_pkg.sv - shared types and constants for the UART frequency-word receiver
package uart_freq_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    typedef enum logic [1:0] {
        P_SYNC,
        P_CHAN,
        P_DATA,
        P_CHK
    } parse_state_t;

    localparam int ERR_FRAME   = 0;
    localparam int ERR_CHK     = 1;
    localparam int ERR_CHAN    = 2;
    localparam int ERR_TIMEOUT = 3;

    function automatic int bytes_for(input int word_w);
        return (word_w + 7) / 8;
    endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - 2-FF synchronised 8N1 byte receiver with framing-error and break handling
module uart_byte_rx
    import uart_freq_pkg::*;
#(
    parameter int CLK_CYCLES_PER_BIT = 521
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_frame_err
);

    localparam int CNT_W = (CLK_CYCLES_PER_BIT > 2) ? $clog2(CLK_CYCLES_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((CLK_CYCLES_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_CYCLES_PER_BIT - 1);

    logic             r_sync1;
    logic             r_sync2;
    rx_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_byte_valid;
    logic             r_frame_err;

    rx_state_t        w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_bit_idx_nxt;
    logic [7:0]       w_shift_nxt;
    logic             w_valid_nxt;
    logic             w_ferr_nxt;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt + 1'b1;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_valid_nxt   = 1'b0;
        w_ferr_nxt    = 1'b0;
        case (r_state)
            RX_IDLE: begin
                w_cnt_nxt = '0;
                if (!r_sync2) w_state_nxt = RX_START;
            end
            RX_START: begin
                if (r_cnt == CNT_MID) begin
                    w_cnt_nxt     = '0;
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = r_sync2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt     = '0;
                    w_shift_nxt   = {r_sync2, r_shift[7:1]};
                    w_bit_idx_nxt = r_bit_idx + 1'b1;
                    if (r_bit_idx == 3'd7) w_state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_sync2) begin
                        w_valid_nxt = 1'b1;
                        w_state_nxt = RX_IDLE;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                // a held-low line (break) must not be decoded as a stream of zero bytes
                w_cnt_nxt = '0;
                if (r_sync2) w_state_nxt = RX_IDLE;
            end
            default: w_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_state      <= RX_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_sync1      <= i_rx;
            r_sync2      <= r_sync1;
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_bit_idx    <= w_bit_idx_nxt;
            r_shift      <= w_shift_nxt;
            r_byte_valid <= w_valid_nxt;
            r_frame_err  <= w_ferr_nxt;
        end
    end

    assign o_byte       = r_shift;
    assign o_byte_valid = r_byte_valid;
    assign o_frame_err  = r_frame_err;

endmodule

// File: rtl/uart_freq_rx.sv
// rtl/uart_freq_rx.sv - framed, checksummed, channel-addressed frequency word loader over UART
module uart_freq_rx
    import uart_freq_pkg::*;
#(
    parameter int         CLK_CYCLES_PER_BIT = 521,
    parameter int         NUM_CH             = 2,
    parameter int         WORD_W             = 16,
    parameter logic [7:0] SYNC_BYTE          = 8'hA5,
    parameter int         TIMEOUT_BITS       = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx,
    output logic [NUM_CH*WORD_W-1:0] freq,
    output logic [NUM_CH-1:0]        update,
    output logic [3:0]               err
);

    localparam int BYTES    = bytes_for(WORD_W);
    localparam int IDX_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int TO_LIMIT = TIMEOUT_BITS * CLK_CYCLES_PER_BIT;
    localparam int TO_W     = $clog2(TO_LIMIT + 1);

    parse_state_t             r_state;
    logic [7:0]               r_ch;
    logic [7:0]               r_xor;
    logic [IDX_W-1:0]         r_idx;
    logic [BYTES*8-1:0]       r_shadow;
    logic [TO_W-1:0]          r_to;
    logic [NUM_CH*WORD_W-1:0] r_freq;
    logic [NUM_CH-1:0]        r_update;
    logic [3:0]               r_err;

    logic [7:0]   w_byte;
    logic         w_bv;
    logic         w_ferr;
    parse_state_t w_state_nxt;
    logic [3:0]   w_err_nxt;
    logic         w_commit;
    logic         w_timeout;
    logic         w_chan_ok;

    uart_byte_rx #(
        .CLK_CYCLES_PER_BIT(CLK_CYCLES_PER_BIT)
    ) u_byte_rx (
        .clk          (clk),
        .rst          (rst),
        .i_rx         (rx),
        .o_byte       (w_byte),
        .o_byte_valid (w_bv),
        .o_frame_err  (w_ferr)
    );

    assign w_timeout = (r_state != P_SYNC) && (r_to == TO_W'(TO_LIMIT));
    assign w_chan_ok = ({1'b0, r_ch} < 9'(NUM_CH));

    always_comb begin
        w_state_nxt            = r_state;
        w_err_nxt              = '0;
        w_commit               = 1'b0;
        w_err_nxt[ERR_FRAME]   = w_ferr;
        if (w_ferr) begin
            w_state_nxt = P_SYNC;
        end else if (w_bv) begin
            case (r_state)
                P_SYNC: if (w_byte == SYNC_BYTE) w_state_nxt = P_CHAN;
                P_CHAN: w_state_nxt = P_DATA;
                P_DATA: if (r_idx == IDX_W'(BYTES - 1)) w_state_nxt = P_CHK;
                P_CHK: begin
                    w_state_nxt = P_SYNC;
                    if (w_byte != r_xor)  w_err_nxt[ERR_CHK]  = 1'b1;
                    else if (!w_chan_ok)  w_err_nxt[ERR_CHAN] = 1'b1;
                    else                  w_commit            = 1'b1;
                end
                default: w_state_nxt = P_SYNC;
            endcase
        end else if (w_timeout) begin
            w_err_nxt[ERR_TIMEOUT] = 1'b1;
            w_state_nxt            = P_SYNC;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= P_SYNC;
            r_ch     <= '0;
            r_xor    <= '0;
            r_idx    <= '0;
            r_shadow <= '0;
            r_to     <= '0;
            r_freq   <= '0;
            r_update <= '0;
            r_err    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err_nxt;
            r_to    <= (w_bv || w_state_nxt == P_SYNC) ? '0 : r_to + 1'b1;
            if (w_bv) begin
                case (r_state)
                    P_CHAN: begin
                        r_ch  <= w_byte;
                        r_xor <= w_byte;
                        r_idx <= '0;
                    end
                    P_DATA: begin
                        r_shadow[r_idx*8 +: 8] <= w_byte;
                        r_xor                  <= r_xor ^ w_byte;
                        r_idx                  <= r_idx + 1'b1;
                    end
                    default: ;
                endcase
            end
            // the addressed word and its strobe change together; all others hold
            r_update <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_commit && r_ch == 8'(c)) begin
                    r_update[c]                  <= 1'b1;
                    r_freq[c*WORD_W +: WORD_W]   <= r_shadow[WORD_W-1:0];
                end
            end
        end
    end

    assign freq   = r_freq;
    assign update = r_update;
    assign err    = r_err;

endmodule

// File: tb/tb_uart_freq_rx.sv
// tb/tb_uart_freq_rx.sv - self-checking bench for uart_freq_rx with a frame-level reference model
module tb_uart_freq_rx;

    localparam int         CPB   = 16;
    localparam int         NCH   = 2;
    localparam int         WW    = 16;
    localparam int         TOB   = 32;
    localparam logic [7:0] SYNC  = 8'hA5;
    localparam int         LIMIT = TOB * CPB;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                rx  = 1'b1;
    logic [NCH*WW-1:0]   freq;
    logic [NCH-1:0]      update;
    logic [3:0]          err;

    uart_freq_rx #(
        .CLK_CYCLES_PER_BIT (CPB),
        .NUM_CH             (NCH),
        .WORD_W             (WW),
        .SYNC_BYTE          (SYNC),
        .TIMEOUT_BITS       (TOB)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .rx     (rx),
        .freq   (freq),
        .update (update),
        .err    (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int upd_cnt[NCH];
    int err_cnt[4];
    int bad_hot = 0;
    int dbl_upd = 0;
    int last_to_cyc = 0;
    logic prev_upd = 1'b0;
    logic [WW-1:0] exp_freq[NCH];

    always @(negedge clk) begin
        cyc++;
        if (|update) begin
            for (int c = 0; c < NCH; c++) if (update[c]) upd_cnt[c]++;
            if ($countones(update) != 1) bad_hot++;
            if (prev_upd) dbl_upd++;
        end
        prev_upd = |update;
        for (int e = 0; e < 4; e++) if (err[e]) err_cnt[e]++;
        if (err[3]) last_to_cyc = cyc;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NCH*WW-1:0] model_bus();
        logic [NCH*WW-1:0] v;
        for (int c = 0; c < NCH; c++) v[c*WW +: WW] = exp_freq[c];
        return v;
    endfunction

    task automatic tx_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic tx_byte(input logic [7:0] b, input logic stop);
        tx_bit(1'b0);
        for (int i = 0; i < 8; i++) tx_bit(b[i]);
        tx_bit(stop);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        if (n > 0) begin
            repeat (n * CPB) @(posedge clk);
            #1;
        end
    endtask

    task automatic check_deltas(input string tag, input int u0[NCH], input int e0[4],
                                input int exp_ch, input int e_frm, input int e_chk,
                                input int e_chan, input int e_to);
        for (int c = 0; c < NCH; c++)
            chk($sformatf("%s:upd%0d", tag, c), 64'(upd_cnt[c] - u0[c]), 64'(exp_ch == c));
        chk({tag, ":err_frame"},   64'(err_cnt[0] - e0[0]), 64'(e_frm));
        chk({tag, ":err_chk"},     64'(err_cnt[1] - e0[1]), 64'(e_chk));
        chk({tag, ":err_chan"},    64'(err_cnt[2] - e0[2]), 64'(e_chan));
        chk({tag, ":err_timeout"}, 64'(err_cnt[3] - e0[3]), 64'(e_to));
        chk({tag, ":freq"}, 64'(freq), 64'(model_bus()));
    endtask

    task automatic send_frame(input string tag, input int n_junk, input logic [7:0] junk0,
                              input logic [7:0] ch, input logic [WW-1:0] word,
                              input logic [7:0] chk_b, input int max_gap);
        int u0[NCH];
        int e0[4];
        logic [7:0] b;
        logic good;
        int exp_ch;
        u0 = upd_cnt;
        e0 = err_cnt;
        good   = (chk_b == (ch ^ word[7:0] ^ word[15:8]));
        exp_ch = (good && int'(ch) < NCH) ? int'(ch) : -1;
        for (int j = 0; j < n_junk; j++) begin
            b = (j == 0) ? junk0 : 8'($urandom);
            if (b == SYNC) b = 8'h5A;
            tx_byte(b, 1'b1);
            idle_bits($urandom_range(0, max_gap));
        end
        tx_byte(SYNC, 1'b1);       idle_bits($urandom_range(0, max_gap));
        tx_byte(ch, 1'b1);         idle_bits($urandom_range(0, max_gap));
        tx_byte(word[7:0], 1'b1);  idle_bits($urandom_range(0, max_gap));
        tx_byte(word[15:8], 1'b1); idle_bits($urandom_range(0, max_gap));
        tx_byte(chk_b, 1'b1);
        idle_bits(3);
        if (exp_ch >= 0) exp_freq[exp_ch] = word;
        check_deltas(tag, u0, e0, exp_ch, 0, good ? 0 : 1, (good && exp_ch < 0) ? 1 : 0, 0);
    endtask

    initial begin
        int u0[NCH];
        int e0[4];
        int r, sh, t_end, lat;
        logic [7:0]    ch, cb;
        logic [WW-1:0] w;

        for (int c = 0; c < NCH; c++) exp_freq[c] = '0;
        repeat (4) @(posedge clk);
        #1;
        chk("reset:freq",   64'(freq),   64'(0));
        chk("reset:update", 64'(update), 64'(0));
        chk("reset:err",    64'(err),    64'(0));
        rst = 1'b1;
        idle_bits(2);

        send_frame("t1",  0, 8'h00, 8'h00, 16'h1234, 8'h26, 0);
        send_frame("t2a", 0, 8'h00, 8'h01, 16'hABCD, 8'h67, 0);
        send_frame("t2b", 0, 8'h00, 8'h00, 16'h0001, 8'h01, 0);
        send_frame("t3a", 0, 8'h00, 8'h00, 16'h1234, 8'h27, 0);
        send_frame("t3b", 0, 8'h00, 8'h00, 16'h5678, 8'h2E, 0);
        send_frame("t4a", 0, 8'h00, 8'h02, 16'h0000, 8'h02, 0);
        send_frame("t4b", 1, 8'h55, 8'h00, 16'h00FF, 8'hFF, 0);

        u0 = upd_cnt;
        e0 = err_cnt;
        for (int i = 0; i < 10; i++) tx_bit(1'b0);
        rx = 1'b0;
        repeat (100 * CPB) @(posedge clk);
        #1;
        idle_bits(2);
        check_deltas("t5a", u0, e0, -1, 1, 0, 0, 0);
        send_frame("t5b", 0, 8'h00, 8'h01, 16'h2468, 8'h01 ^ 8'h68 ^ 8'h24, 0);

        u0 = upd_cnt;
        e0 = err_cnt;
        tx_byte(SYNC, 1'b1);
        tx_byte(8'h00, 1'b1);
        tx_byte(8'h34, 1'b1);
        t_end = cyc;
        idle_bits(40);
        check_deltas("t6a", u0, e0, -1, 0, 0, 0, 1);
        lat = last_to_cyc - t_end;
        chk("t6a:timeout_latency_in_window",
            64'((lat >= LIMIT - CPB) && (lat <= LIMIT + CPB)), 64'(1));

        tx_byte(SYNC, 1'b1);
        tx_byte(8'h00, 1'b1);
        tx_byte(8'h34, 1'b1);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int c = 0; c < NCH; c++) exp_freq[c] = '0;
        chk("t6b:freq",   64'(freq),   64'(model_bus()));
        chk("t6b:update", 64'(update), 64'(0));
        chk("t6b:err",    64'(err),    64'(0));
        rst = 1'b1;
        idle_bits(1);
        send_frame("t6c", 0, 8'h00, 8'h01, 16'hBEEF, 8'h50, 0);

        for (int i = 0; i < 30; i++) begin
            r  = $urandom_range(0, 9);
            ch = (r < 4) ? 8'd0 : (r < 8) ? 8'd1 : (r == 8) ? 8'd2 : 8'($urandom_range(3, 255));
            w  = WW'($urandom);
            cb = ch ^ w[7:0] ^ w[15:8];
            if ($urandom_range(0, 4) == 0) begin
                sh = $urandom_range(0, 7);
                cb = cb ^ (8'd1 << sh);
            end
            send_frame($sformatf("rnd%0d", i), $urandom_range(0, 2), 8'($urandom), ch, w, cb, 1);
        end

        chk("update_onehot",     64'(bad_hot), 64'(0));
        chk("update_single_cyc", 64'(dbl_upd), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
